// File: rtl/riscv_types.sv
// Shared types for the core's data-memory interface: request/response structs,
// default data RAM depth and the clear-FSM state encoding.
package riscv_types;

    localparam int DMEM_DEPTH_DEFAULT = 1024;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } MemoryRequest;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } MemoryResponse;

    typedef enum logic {
        DMEM_CLEAR = 1'b0,
        DMEM_RUN   = 1'b1
    } DmemState;

endpackage

// File: rtl/data_bram_sp.sv
// Single-port, byte-write-enable, read-first block RAM with a registered read
// and an optional second output register.
module data_bram_sp #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 1024,
    parameter int OUT_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic [WIDTH/8-1:0]       we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    // Read-first: the read register captures the word as it was before this edge's write.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rd_q <= mem[addr_i];
            for (int b = 0; b < NB; b++) begin
                if (we_i[b]) begin
                    mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] out_q;
            always_ff @(posedge clk_i) begin
                out_q <= rd_q;
            end
            assign rdata_o = out_q;
        end else begin : g_no_out_reg
            assign rdata_o = rd_q;
        end
    endgenerate

endmodule

// File: rtl/riscv_data_mem.sv
// Data-memory responder: word-organised RAM behind a fixed-latency, in-order
// request/response pipeline, with a post-reset clear pass before requests are admitted.
module riscv_data_mem
    import riscv_types::*;
#(
    parameter int DEPTH        = DMEM_DEPTH_DEFAULT,
    parameter int READ_LATENCY = 2,
    parameter int INIT_CLEAR   = 1
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  MemoryRequest  req_in,
    output logic          req_ready_out,
    output MemoryResponse rsp_out,
    output logic          busy_out
);

    localparam int AW    = $clog2(DEPTH);
    localparam int L     = READ_LATENCY;
    localparam int EXTRA = READ_LATENCY - 2;

    DmemState        state_q;
    logic [AW-1:0]   clr_idx_q;
    logic            ready_q;
    logic            busy_q;

    logic            accept;
    logic            in_range;
    logic            ram_en;
    logic [3:0]      ram_we;
    logic [AW-1:0]   ram_addr;
    logic [31:0]     ram_wdata;
    logic [31:0]     ram_rdata;
    logic [31:0]     rsp_data;
    logic [L-1:0]    vld_q, err_q, wr_q;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^req_in.addr[1:0];

    // Clear FSM: one word zeroed per cycle, then RUN until the next reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= (INIT_CLEAR != 0) ? DMEM_CLEAR : DMEM_RUN;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= (INIT_CLEAR != 0);
        end else begin
            case (state_q)
                DMEM_CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == AW'(DEPTH - 1)) begin
                        state_q <= DMEM_RUN;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                DMEM_RUN: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= DMEM_RUN;
                end
            endcase
        end
    end

    assign req_ready_out = ready_q;
    assign busy_out      = busy_q;
    assign accept        = req_in.valid && ready_q;
    assign in_range      = (req_in.addr[31:AW+2] == '0);

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = '0;
        ram_addr  = req_in.addr[AW+1:2];
        ram_wdata = req_in.wdata;
        if (state_q == DMEM_CLEAR) begin
            ram_en    = 1'b1;
            ram_we    = 4'hF;
            ram_addr  = clr_idx_q;
            ram_wdata = '0;
        end else if (accept && in_range) begin
            ram_en = 1'b1;
            ram_we = req_in.we ? req_in.wstrb : 4'h0;
        end
    end

    data_bram_sp #(
        .WIDTH   (32),
        .DEPTH   (DEPTH),
        .OUT_REG (1)
    ) u_bram (
        .clk_i   (clk_in),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Response tags travel alongside the RAM read path; valid bits drop on reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_q <= '0;
            err_q <= '0;
            wr_q  <= '0;
        end else begin
            vld_q <= {vld_q[L-2:0], accept};
            err_q <= {err_q[L-2:0], ~in_range};
            wr_q  <= {wr_q[L-2:0], req_in.we};
        end
    end

    generate
        if (EXTRA > 0) begin : g_extra_dly
            logic [31:0] dly_q [EXTRA];
            always_ff @(posedge clk_in) begin
                dly_q[0] <= ram_rdata;
                for (int i = 1; i < EXTRA; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
            assign rsp_data = dly_q[EXTRA-1];
        end else begin : g_no_extra_dly
            assign rsp_data = ram_rdata;
        end
    endgenerate

    // Only in-range reads put data on the bus; everything else drives zero.
    always_comb begin
        rsp_out       = '0;
        rsp_out.valid = vld_q[L-1];
        rsp_out.err   = vld_q[L-1] & err_q[L-1];
        if (vld_q[L-1] && !err_q[L-1] && !wr_q[L-1]) begin
            rsp_out.rdata = rsp_data;
        end
    end

endmodule

// File: tb/tb_riscv_data_mem.sv
// Directed bench for riscv_data_mem with DEPTH=16, READ_LATENCY=2, INIT_CLEAR=1.
module tb_riscv_data_mem;
    import riscv_types::*;

    logic          clk;
    logic          rst_n;
    MemoryRequest  req;
    logic          ready;
    MemoryResponse rsp;
    logic          busy;

    int checks = 0;
    int errors = 0;

    riscv_data_mem #(
        .DEPTH        (16),
        .READ_LATENCY (2),
        .INIT_CLEAR   (1)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .req_in        (req),
        .req_ready_out (ready),
        .rsp_out       (rsp),
        .busy_out      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] b2b_val(int i);
        return 32'hA500_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic we, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        req.valid = 1'b1;
        req.we    = we;
        req.addr  = a;
        req.wdata = d;
        req.wstrb = s;
        tick();
        req = '0;
    endtask

    task automatic chk_rsp(string tag, logic v, logic e, logic [31:0] d);
        checks++;
        assert ({rsp.valid, rsp.err, rsp.rdata} === {v, e, d})
        else begin
            errors++;
            $error("FAIL %s observed valid=%b err=%b rdata=%h expected valid=%b err=%b rdata=%h",
                   tag, rsp.valid, rsp.err, rsp.rdata, v, e, d);
        end
    endtask

    task automatic chk_ctl(string tag, logic [2:0] exp);
        checks++;
        assert ({busy, ready, rsp.valid} === exp)
        else begin
            errors++;
            $error("FAIL %s observed busy/ready/valid=%b expected %b",
                   tag, {busy, ready, rsp.valid}, exp);
        end
    endtask

    task automatic write_chk(string tag, logic [31:0] a, logic [31:0] d, logic [3:0] s, logic e);
        drive(1'b1, a, d, s);
        tick();
        chk_rsp(tag, 1'b1, e, 32'h0);
    endtask

    task automatic read_chk(string tag, logic [31:0] a, logic [31:0] exp, logic e);
        drive(1'b0, a, 32'h0, 4'hF);
        chk_rsp({tag, "_lat"}, 1'b0, 1'b0, 32'h0);
        tick();
        chk_rsp(tag, 1'b1, e, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_rsp("rst_rsp", 1'b0, 1'b0, 32'h0);
        chk_ctl("rst_ctl", 3'b100);
        rst_n = 1'b1;

        // Clear pass: exactly 16 cycles busy, then ready.
        for (int i = 0; i < 16; i++) begin
            chk_ctl("clear", 3'b100);
            tick();
        end
        chk_ctl("run", 3'b010);

        // Back-to-back sweep of the whole RAM: every word reads zero.
        for (int i = 0; i < 18; i++) begin
            if (i < 16) drive(1'b0, 32'(i * 4), 32'h0, 4'h0);
            else        tick();
            if (i >= 1 && i <= 16) chk_rsp("sweep", 1'b1, 1'b0, 32'h0);
            else                   chk_rsp("sweep_idle", 1'b0, 1'b0, 32'h0);
        end

        // Read-after-write in the next cycle.
        drive(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111);
        drive(1'b0, 32'h10, 32'h0, 4'h0);
        chk_rsp("raw_wr_rsp", 1'b1, 1'b0, 32'h0);
        tick();
        chk_rsp("raw_rd", 1'b1, 1'b0, 32'hDEAD_BEEF);
        tick();
        chk_rsp("raw_idle", 1'b0, 1'b0, 32'h0);

        // Byte-lane writes.
        write_chk("strb0_wr", 32'h10, 32'h0000_00AA, 4'b0001, 1'b0);
        read_chk("strb0_rd", 32'h10, 32'hDEAD_BEAA, 1'b0);
        write_chk("strb2_wr", 32'h10, 32'h0055_0000, 4'b0100, 1'b0);
        read_chk("strb2_rd", 32'h10, 32'hDE55_BEAA, 1'b0);

        // Eight back-to-back reads of distinct words.
        for (int i = 0; i < 8; i++) begin
            write_chk("b2b_wr", 32'(i * 4), b2b_val(i), 4'hF, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b0, 32'(i * 4), 32'h0, 4'h0);
            else       tick();
            if (i >= 1 && i <= 8) chk_rsp("b2b_rd", 1'b1, 1'b0, b2b_val(i - 1));
            else                  chk_rsp("b2b_idle", 1'b0, 1'b0, 32'h0);
        end

        // Out-of-range accesses must not alias onto word 0.
        read_chk("oor_rd", 32'h40, 32'h0, 1'b1);
        write_chk("oor_wr", 32'h40, 32'hFFFF_FFFF, 4'hF, 1'b1);
        read_chk("oor_word0", 32'h0, b2b_val(0), 1'b0);

        // Reset with two reads in flight.
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b0, 32'h4, 32'h0, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_ctl("rst_async", 3'b100);
        repeat (2) @(posedge clk);
        #1;
        chk_ctl("rst_hold", 3'b100);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk_ctl("reclear", 3'b100);
            tick();
        end
        chk_ctl("rerun", 3'b010);
        read_chk("reclr_w0", 32'h0, 32'h0, 1'b0);
        read_chk("reclr_w1", 32'h4, 32'h0, 1'b0);
        read_chk("reclr_w4", 32'h10, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
